datapath_pipe: RTL and testbench
================================

Name: datapath_pipe

Overview:
- Parametrised two-stage successor to the single-cycle CPU datapath.
- Stage EX: operand read with forwarding, ALU evaluation, write-source mux, flag generation.
- Stage WB: registered result committed to the internal register file one cycle later.
- Sits between the control FSM (issue/pause) and data RAM (load data in, operands out for address/store).

Parameters:
- DATA_W, 8, datapath/register width in bits (>=4).
- REG_CNT, 16, number of architectural registers (power of 2, >=2); register 0 reads as zero.
- ADDR_W, $clog2(REG_CNT), derived localparam, register address width; not overridable.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  an instruction is presented this cycle.
- alu_opcode  in  3  ALU operation (encoding below).
- write_alu  in  1  write source = ALU result.
- is_load  in  1  write source = ram_data.
- imm_flag  in  1  ALU operand B = imm_data instead of rb.
- write_en  in  1  instruction writes write_addr.
- write_addr, ra_addr, rb_addr  in  ADDR_W each  destination and source registers.
- imm_data, ram_data  in  DATA_W each  immediate; RAM read data, valid in the issue cycle.
- cpu_paused  in  1  freeze all state.
- read_a, read_b  out  DATA_W each  forwarded source operands (combinational).
- alu_out  out  DATA_W  registered EX result (WB stage data).
- alu_zero, alu_carry  out  1 each  registered flags.
- wb_valid  out  1  WB stage holds a pending register write.
- busy  out  1  EX occupied by a multi-cycle op; issue ignored.

Behaviour:
- Accept: issue_valid & ~cpu_paused & ~busy & ~rst. Unaccepted cycles capture nothing and leave flags unchanged.
- Write-source priority: write_alu (ALU) > is_load (ram_data) > imm_data. If both write_alu and is_load are set, ALU wins.
- Opcodes and results:
  - 000 ADD: carry = bit DATA_W of the sum.
  - 001 SUB: carry = borrow (a<b unsigned).
  - 010 AND, 011 OR, 100 XOR: carry=0.
  - 101 SHL by 1: carry = a[MSB].
  - 110 SHR logical by 1: carry = a[0].
  - 111: see Optional Feature.
- Flags: zero = (result==0). Flags update only on accepted write_alu instructions and hold otherwise.
- On accept, the WB register captures {write_en & write_addr!=0, write_addr, write data}. alu_out shows the captured data next cycle.
- Commit: wb_valid & ~cpu_paused writes the register file at that edge. wb_valid clears unless a new instruction is accepted in the same cycle.
- Forwarding (read_a/read_b, ALU operands), in priority order:
  - address 0 gives 0;
  - otherwise WB hit (wb_valid & wb_addr==addr) gives WB data;
  - otherwise register file contents.
- Back-to-back dependent instructions need no stall. Write to register 0 is discarded and never sets wb_valid.
- cpu_paused: WB register, flags, register file and multiply state all hold. The pending write commits on the first unpaused edge.
- Reset:
  - all registers, alu_out, alu_zero, alu_carry cleared to 0;
  - wb_valid=0, busy=0;
  - any in-flight multiply is aborted. Reset overrides pause and issue.

Optional Feature:
- Macro: DATAPATH_MUL_EN.
- Defined: opcode 111 = unsigned multiply, low DATA_W bits written, carry = OR of the high half.
  - Shift-add iterative, DATA_W cycles.
  - Accept cycle latches operands and sets busy. busy stays high exactly DATA_W cycles (pause-stalled cycles excluded).
  - Final cycle loads WB and flags, and busy falls.
  - Operands are forwarded at accept time only.
- Undefined: opcode 111 = pass B (carry=0), single cycle, busy tied 0.

Decomposition:
- Package datapath_pkg:
  - opcode localparams (OP_ADD..OP_111);
  - write-source encoding (SRC_IMM, SRC_LOAD, SRC_ALU);
  - default DATA_W/REG_CNT constants.
- Sub-module alu_unit (parametrised DATA_W): combinational result/zero/carry for opcodes 000-110 and pass-B. The multiply sequencer stays in datapath_pipe.

Test Plan:
- Reset then read all regs -> read_a=read_b=0, flags 0, wb_valid=0, busy=0.
- Immediate write r1=0x05, next cycle ADD r2=r1+imm 0xFB (back-to-back, forwarded) -> alu_out=0x00, zero=1, carry=1; r2 reads 0x00 after commit.
- SUB r3=r1-r1 then SUB r4=r0-r1 -> first zero=1 carry=0; second result 0xFB, carry=1; non-ALU load between them leaves flags unchanged.
- Load r5=ram 0xA7 with cpu_paused asserted during WB -> wb_valid held, r5 unchanged while paused; reads 0xA7 (forwarded) throughout and commits on first unpaused edge.
- Write r0=0xFF (imm) -> wb_valid stays 0; read_a(r0)=0.
- DATAPATH_MUL_EN: MUL 0x10*0x11 -> busy high 8 cycles, issue ignored meanwhile, result 0x10, carry=1; rst on cycle 4 -> busy=0, no write.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants for the pipelined datapath: opcodes, write-source codes, default sizes.
package datapath_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_REG_CNT = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_111 = 3'b111;

  localparam logic [1:0] SRC_IMM  = 2'd0;
  localparam logic [1:0] SRC_LOAD = 2'd1;
  localparam logic [1:0] SRC_ALU  = 2'd2;

endpackage

// File: rtl/datapath_pipe_alu.sv
// Combinational ALU: single-cycle opcodes plus pass-B for opcode 111.
module alu_unit
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        op_i,
  output logic [DATA_W-1:0] result_c,
  output logic              zero_c,
  output logic              carry_c
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  // Result and carry per opcode; diff[DATA_W] is the unsigned borrow.
  always_comb begin
    result_c = '0;
    carry_c  = 1'b0;
    case (op_i)
      OP_ADD: begin result_c = sum[DATA_W-1:0];  carry_c = sum[DATA_W];  end
      OP_SUB: begin result_c = diff[DATA_W-1:0]; carry_c = diff[DATA_W]; end
      OP_AND: result_c = a_i & b_i;
      OP_OR:  result_c = a_i | b_i;
      OP_XOR: result_c = a_i ^ b_i;
      OP_SHL: begin result_c = {a_i[DATA_W-2:0], 1'b0}; carry_c = a_i[DATA_W-1]; end
      OP_SHR: begin result_c = {1'b0, a_i[DATA_W-1:1]}; carry_c = a_i[0];        end
      OP_111: result_c = b_i;
      default: ;
    endcase
  end

  assign zero_c = (result_c == '0);

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage datapath (EX with forwarding, WB commit into register file).
// Optional iterative multiply on opcode 111 when DATAPATH_MUL_EN is defined.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter  int unsigned DATA_W  = DEF_DATA_W,
  parameter  int unsigned REG_CNT = DEF_REG_CNT,
  localparam int unsigned ADDR_W  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [2:0]        alu_opcode,
  input  logic              write_alu,
  input  logic              is_load,
  input  logic              imm_flag,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [DATA_W-1:0] imm_data,
  input  logic [DATA_W-1:0] ram_data,
  input  logic              cpu_paused,
  output logic [DATA_W-1:0] read_a,
  output logic [DATA_W-1:0] read_b,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_zero,
  output logic              alu_carry,
  output logic              wb_valid,
  output logic              busy
);

  logic [DATA_W-1:0] rf_q [REG_CNT];
  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              zero_q;
  logic              carry_q;

  logic              accept;
  logic              busy_w;
  logic              mul_start;
  logic              wb_valid_d;
  logic [1:0]        src_sel;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_z;
  logic              alu_c;
  logic [DATA_W-1:0] wr_data_d;

  // Operand read: r0 is zero, then the pending WB value, then the register file.
  always_comb begin
    read_a = rf_q[ra_addr];
    read_b = rf_q[rb_addr];
    if (ra_addr == '0) read_a = '0;
    else if (wb_valid_q && (wb_addr_q == ra_addr)) read_a = wb_data_q;
    if (rb_addr == '0) read_b = '0;
    else if (wb_valid_q && (wb_addr_q == rb_addr)) read_b = wb_data_q;
  end

  assign accept     = issue_valid & ~cpu_paused & ~busy_w & ~rst;
  assign op_b       = imm_flag ? imm_data : read_b;
  assign wb_valid_d = write_en & (write_addr != '0);

  alu_unit #(.DATA_W(DATA_W)) u_alu (
    .a_i      (read_a),
    .b_i      (op_b),
    .op_i     (alu_opcode),
    .result_c (alu_res),
    .zero_c   (alu_z),
    .carry_c  (alu_c)
  );

  // Write-source select: ALU beats load beats immediate.
  always_comb begin
    src_sel = SRC_IMM;
    if (write_alu)    src_sel = SRC_ALU;
    else if (is_load) src_sel = SRC_LOAD;
    case (src_sel)
      SRC_ALU:  wr_data_d = alu_res;
      SRC_LOAD: wr_data_d = ram_data;
      default:  wr_data_d = imm_data;
    endcase
  end

`ifdef DATAPATH_MUL_EN
  typedef enum logic {ST_IDLE, ST_MUL} mul_state_e;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  mul_state_e          state_q;
  logic [2*DATA_W-1:0] mul_p_q;
  logic [2*DATA_W-1:0] mul_p_d;
  logic [DATA_W-1:0]   mul_mcand_q;
  logic [CNT_W-1:0]    mul_cnt_q;
  logic [ADDR_W-1:0]   mul_addr_q;
  logic                mul_wen_q;
  logic [DATA_W:0]     mul_sum;
  logic                mul_last;

  // Shift-add step: add multiplicand into the high half when the low bit is set, then shift right.
  assign mul_start = accept & write_alu & (alu_opcode == OP_111);
  assign mul_last  = (mul_cnt_q == CNT_W'(DATA_W - 1));
  assign mul_sum   = {1'b0, mul_p_q[2*DATA_W-1:DATA_W]} + {1'b0, {DATA_W{mul_p_q[0]}} & mul_mcand_q};
  assign mul_p_d   = {mul_sum, mul_p_q[DATA_W-1:1]};
  assign busy_w    = (state_q == ST_MUL);
`else
  assign mul_start = 1'b0;
  assign busy_w    = 1'b0;
`endif

  // Pipeline state: WB register, flags, register file commit and multiply sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_CNT); i++) rf_q[i] <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
`ifdef DATAPATH_MUL_EN
      state_q     <= ST_IDLE;
      mul_p_q     <= '0;
      mul_mcand_q <= '0;
      mul_cnt_q   <= '0;
      mul_addr_q  <= '0;
      mul_wen_q   <= 1'b0;
`endif
    end else if (!cpu_paused) begin
      if (wb_valid_q) rf_q[wb_addr_q] <= wb_data_q;
      wb_valid_q <= 1'b0;
      if (accept && !mul_start) begin
        wb_valid_q <= wb_valid_d;
        wb_addr_q  <= write_addr;
        wb_data_q  <= wr_data_d;
        if (write_alu) begin
          zero_q  <= alu_z;
          carry_q <= alu_c;
        end
      end
`ifdef DATAPATH_MUL_EN
      case (state_q)
        ST_IDLE: begin
          if (mul_start) begin
            state_q     <= ST_MUL;
            mul_p_q     <= {{DATA_W{1'b0}}, op_b};
            mul_mcand_q <= read_a;
            mul_cnt_q   <= '0;
            mul_addr_q  <= write_addr;
            mul_wen_q   <= wb_valid_d;
          end
        end
        ST_MUL: begin
          mul_p_q   <= mul_p_d;
          mul_cnt_q <= mul_cnt_q + CNT_W'(1);
          if (mul_last) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= mul_wen_q;
            wb_addr_q  <= mul_addr_q;
            wb_data_q  <= mul_p_d[DATA_W-1:0];
            zero_q     <= (mul_p_d[DATA_W-1:0] == '0);
            carry_q    <= |mul_p_d[2*DATA_W-1:DATA_W];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
`endif
    end
  end

  assign alu_out   = wb_data_q;
  assign alu_zero  = zero_q;
  assign alu_carry = carry_q;
  assign wb_valid  = wb_valid_q;
  assign busy      = busy_w;

endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe; the multiply scenario runs when DATAPATH_MUL_EN is defined.
module tb_datapath_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [2:0] alu_opcode;
  logic       write_alu;
  logic       is_load;
  logic       imm_flag;
  logic       write_en;
  logic [3:0] write_addr;
  logic [3:0] ra_addr;
  logic [3:0] rb_addr;
  logic [7:0] imm_data;
  logic [7:0] ram_data;
  logic       cpu_paused;
  logic [7:0] read_a;
  logic [7:0] read_b;
  logic [7:0] alu_out;
  logic       alu_zero;
  logic       alu_carry;
  logic       wb_valid;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       z;
    logic       c;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_rf [16];
  logic       m_z;
  logic       m_c;

  datapath_pipe #(.DATA_W(8), .REG_CNT(16)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .alu_opcode(alu_opcode),
    .write_alu(write_alu), .is_load(is_load), .imm_flag(imm_flag), .write_en(write_en),
    .write_addr(write_addr), .ra_addr(ra_addr), .rb_addr(rb_addr), .imm_data(imm_data),
    .ram_data(ram_data), .cpu_paused(cpu_paused), .read_a(read_a), .read_b(read_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry), .wb_valid(wb_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU written from the opcode table using integer arithmetic.
  function automatic void model_alu(input logic [2:0] op, input int a, input int b,
                                    output int r, output logic c);
    c = 1'b0;
    case (op)
      3'd0: begin r = a + b; c = (r > 255); end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a * 2; c = (a >= 128); end
      3'd6: begin r = a / 2; c = (a % 2) == 1; end
      default: r = b;
    endcase
    r = r & 255;
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] addr);
    return (addr == 4'd0) ? 8'h00 : exp_rf[addr];
  endfunction

  // Issue one instruction, push its expected WB image, compare when it appears after the edge.
  task automatic do_issue(input string tag, input logic [2:0] op, input logic s_alu,
                          input logic s_ld, input logic we, input logic [3:0] wa,
                          input logic [3:0] ra, input logic [3:0] rb, input logic immf,
                          input logic [7:0] imm, input logic [7:0] ram);
    exp_t e;
    int   r;
    logic c;
    logic [7:0] opb;
    @(negedge clk);
    issue_valid = 1'b1; alu_opcode = op; write_alu = s_alu; is_load = s_ld;
    write_en = we; write_addr = wa; ra_addr = ra; rb_addr = rb; imm_flag = immf;
    imm_data = imm; ram_data = ram;
    opb = immf ? imm : m_read(rb);
    model_alu(op, int'(m_read(ra)), int'(opb), r, c);
    e.d = s_alu ? 8'(r) : (s_ld ? ram : imm);
    e.v = we && (wa != 4'd0);
    if (s_alu) begin m_z = (r == 0); m_c = c; end
    e.z = m_z; e.c = m_c;
    sb.push_back(e);
    if (e.v) exp_rf[wa] = e.d;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (alu_out !== e.d) begin n_fail++; $display("FAIL %s alu_out got %h want %h", tag, alu_out, e.d); end
      n_checks++;
      if (wb_valid !== e.v) begin n_fail++; $display("FAIL %s wb_valid got %b want %b", tag, wb_valid, e.v); end
      n_checks++;
      if (alu_zero !== e.z) begin n_fail++; $display("FAIL %s zero got %b want %b", tag, alu_zero, e.z); end
      n_checks++;
      if (alu_carry !== e.c) begin n_fail++; $display("FAIL %s carry got %b want %b", tag, alu_carry, e.c); end
    end
  endtask

  // Read a register on both ports and compare against the model.
  task automatic check_reg(input string tag, input logic [3:0] addr);
    @(negedge clk);
    ra_addr = addr; rb_addr = addr;
    #1;
    n_checks++;
    if (read_a !== m_read(addr)) begin n_fail++; $display("FAIL %s read_a r%0d got %h want %h", tag, addr, read_a, m_read(addr)); end
    n_checks++;
    if (read_b !== m_read(addr)) begin n_fail++; $display("FAIL %s read_b r%0d got %h want %h", tag, addr, read_b, m_read(addr)); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_paused = 1'b1; issue_valid = 1'b1; alu_opcode = 3'd0;
    write_alu = 1'b0; is_load = 1'b0; imm_flag = 1'b1; write_en = 1'b1;
    write_addr = 4'd1; ra_addr = 4'd0; rb_addr = 4'd0; imm_data = 8'h5A; ram_data = 8'h00;
    for (int i = 0; i < 16; i++) exp_rf[i] = 8'h00;
    m_z = 1'b0; m_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cpu_paused = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; issue_valid = 1'b0;
    n_checks++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset wb_valid got %b want 0", wb_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
    n_checks++;
    if ({alu_zero, alu_carry} !== 2'b00) begin n_fail++; $display("FAIL reset flags got %b%b want 00", alu_zero, alu_carry); end
    n_checks++;
    if (alu_out !== 8'h00) begin n_fail++; $display("FAIL reset alu_out got %h want 00", alu_out); end
    for (int i = 0; i < 16; i++) check_reg("reset_regs", 4'(i));
  endtask

  task automatic test_imm_add();
    do_issue("imm_r1", 3'd0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 1'b1, 8'h05, 8'h00);
    do_issue("add_r2", 3'd0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 1'b1, 8'hFB, 8'h00);
    check_reg("add_r2_fwd", 4'd2);
    check_reg("add_r2_rf", 4'd2);
    check_reg("add_r1_rf", 4'd1);
  endtask

  task automatic test_sub_flags();
    do_issue("sub_r3", 3'd1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd1, 4'd1, 1'b0, 8'h00, 8'h00);
    do_issue("load_r6", 3'd0, 1'b0, 1'b1, 1'b1, 4'd6, 4'd0, 4'd0, 1'b0, 8'h00, 8'h33);
    do_issue("sub_r4", 3'd1, 1'b1, 1'b0, 1'b1, 4'd4, 4'd0, 4'd1, 1'b0, 8'h00, 8'h00);
    check_reg("sub_r4", 4'd4);
    do_issue("alu_over_load", 3'd3, 1'b1, 1'b1, 1'b1, 4'd11, 4'd4, 4'd6, 1'b0, 8'h00, 8'hEE);
    check_reg("alu_over_load", 4'd11);
  endtask

  task automatic test_load_pause();
    do_issue("load_r5", 3'd0, 1'b0, 1'b1, 1'b1, 4'd5, 4'd0, 4'd0, 1'b0, 8'h00, 8'hA7);
    cpu_paused = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      issue_valid = 1'b1; write_alu = 1'b0; is_load = 1'b0; imm_flag = 1'b1;
      write_en = 1'b1; write_addr = 4'd6; imm_data = 8'h99; ra_addr = 4'd5; rb_addr = 4'd5;
      #1;
      n_checks++;
      if (read_a !== 8'hA7) begin n_fail++; $display("FAIL pause_fwd read_a got %h want a7", read_a); end
      @(posedge clk); #1;
      n_checks++;
      if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL pause_hold wb_valid got %b want 1", wb_valid); end
      n_checks++;
      if (alu_out !== 8'hA7) begin n_fail++; $display("FAIL pause_hold alu_out got %h want a7", alu_out); end
    end
    @(negedge clk);
    issue_valid = 1'b0; cpu_paused = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL unpause_commit wb_valid got %b want 0", wb_valid); end
    check_reg("load_r5_rf", 4'd5);
    check_reg("pause_ignored_r6", 4'd6);
  endtask

  task automatic test_r0_write();
    do_issue("imm_r0", 3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 8'hFF, 8'h00);
    check_reg("r0_zero", 4'd0);
    do_issue("no_we", 3'd0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 4'd0, 1'b1, 8'h3C, 8'h00);
    check_reg("no_we_r7", 4'd7);
  endtask

  task automatic test_opcodes();
    logic [7:0] a;
    logic [7:0] b;
`ifdef DATAPATH_MUL_EN
    localparam int NOPS = 7;
`else
    localparam int NOPS = 8;
`endif
    for (int op = 0; op < NOPS; op++) begin
      for (int rep = 0; rep < 3; rep++) begin
        a = (rep == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        b = (rep == 0) ? 8'h01 : 8'($urandom_range(0, 255));
        do_issue("imm_a", 3'd0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd0, 4'd0, 1'b1, a, 8'h00);
        do_issue("imm_b", 3'd0, 1'b0, 1'b0, 1'b1, 4'd8, 4'd0, 4'd0, 1'b1, b, 8'h00);
        do_issue("op_rr", 3'(op), 1'b1, 1'b0, 1'b1, 4'd9, 4'd7, 4'd8, 1'b0, 8'h00, 8'h00);
        do_issue("op_dep", 3'(op), 1'b1, 1'b0, 1'b1, 4'd10, 4'd9, 4'd9, 1'b0, 8'h00, 8'h00);
      end
    end
    check_reg("ops_r10", 4'd10);
  endtask

`ifdef DATAPATH_MUL_EN
  task automatic test_mul();
    int busy_cnt;
    do_issue("mul_imm_r1", 3'd0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 1'b1, 8'h10, 8'h00);
    do_issue("mul_imm_r2", 3'd0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 1'b1, 8'h11, 8'h00);
    @(negedge clk);
    issue_valid = 1'b1; alu_opcode = 3'd7; write_alu = 1'b1; is_load = 1'b0; write_en = 1'b1;
    write_addr = 4'd3; ra_addr = 4'd1; rb_addr = 4'd2; imm_flag = 1'b0;
    @(posedge clk); #1;
    write_alu = 1'b0; write_addr = 4'd4; imm_flag = 1'b1; imm_data = 8'h77;
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy !== 1'b1) break;
      busy_cnt++;
      @(posedge clk); #1;
    end
    issue_valid = 1'b0;
    n_checks++;
    if (busy_cnt != 8) begin n_fail++; $display("FAIL mul_busy cycles got %0d want 8", busy_cnt); end
    n_checks++;
    if (alu_out !== 8'h10) begin n_fail++; $display("FAIL mul_result got %h want 10", alu_out); end
    n_checks++;
    if ({wb_valid, alu_zero, alu_carry} !== 3'b101) begin n_fail++; $display("FAIL mul_flags got %b%b%b want 101", wb_valid, alu_zero, alu_carry); end
    exp_rf[3] = 8'h10;
    check_reg("mul_r3", 4'd3);
    check_reg("mul_ignored_r4", 4'd4);
    @(negedge clk);
    issue_valid = 1'b1; alu_opcode = 3'd7; write_alu = 1'b1; write_en = 1'b1;
    write_addr = 4'd5; ra_addr = 4'd1; rb_addr = 4'd2; imm_flag = 1'b0;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_rf[i] = 8'h00;
    n_checks++;
    if ({busy, wb_valid} !== 2'b00) begin n_fail++; $display("FAIL mul_abort busy/wb got %b%b want 00", busy, wb_valid); end
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, wb_valid} !== 2'b00) begin n_fail++; $display("FAIL mul_abort_late busy/wb got %b%b want 00", busy, wb_valid); end
    check_reg("mul_abort_r5", 4'd5);
  endtask
`endif

  initial begin
    test_reset();
    test_imm_add();
    test_sub_flags();
    test_load_pause();
    test_r0_write();
    test_opcodes();
`ifdef DATAPATH_MUL_EN
    test_mul();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
